mem_burst_ctrl: RTL and testbench
=================================

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, bus/array data width.
REQ-002 Parameter ADDR_W, default 16, bus address width; OFF_W = ADDR_W-PAGE_W is the array offset width.
REQ-003 Parameter PAGE_W, default 4, number of upper address bits used for page decode.
REQ-004 Parameter PAGE, default MEMPAGE1, page number this slave answers.
REQ-005 Parameter BURST_LEN, default 4, beats per burst; power of 2, minimum 2.
REQ-006 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  single clock, all state updates on rising edge.
REQ-008 resetN  input  1  asynchronous active-low reset.
REQ-009 AddrValid  input  1  address-phase strobe from bus master.
REQ-010 rw  input  1  sampled with AddrValid; 1 = read, 0 = write.
REQ-011 burst  input  1  sampled with AddrValid; 1 = BURST_LEN beats, 0 = single beat.
REQ-012 wrap  input  1  sampled with AddrValid; 1 = wrapping burst (effective only with MEMCTL_WRAP_EN).
REQ-013 AddrData_in  input  DATA_W  address in address phase, write data in data beats (ADDR_W <= DATA_W).
REQ-014 AddrData_out  output  DATA_W  read data to master, valid when rdValid.
REQ-015 rdValid  output  1  read beat valid on AddrData_out.
REQ-016 busy  output  1  high whenever FSM is not IDLE.
REQ-017 memAddr  output  OFF_W  array word address.
REQ-018 memWE  output  1  array write enable, one per write beat.
REQ-019 memRE  output  1  array read enable, one per read beat.
REQ-020 memWdata  output  DATA_W  array write data, equals AddrData_in in write beat.
REQ-021 memRdata  input  DATA_W  array read data, valid one cycle after memRE.

Function
REQ-022 FSM states SHALL be IDLE, WR, RD, RD_TAIL.
REQ-023 Address phase (cycle A): AddrValid high in IDLE or RD_TAIL and AddrData_in[ADDR_W-1 -: PAGE_W]==PAGE; latch offset, rw, burst, wrap; N = BURST_LEN if burst else 1.
REQ-024 Page mismatch: request ignored, FSM stays/returns IDLE, no memWE/memRE.
REQ-025 Write: WR for cycles A+1..A+N; beat k: memWE=1, memAddr=beat address k, memWdata=AddrData_in; after beat N-1 -> IDLE.
REQ-026 Read: RD for cycles A+1..A+N issues memRE with beat address k; then RD_TAIL for one cycle -> IDLE.
REQ-027 Read latency: rdValid=1 and AddrData_out=memRdata in cycles A+2..A+N+1, one beat per cycle in order; AddrData_out=0 when rdValid=0.
REQ-028 Linear beat address k = (offset + k) mod 2^OFF_W; offset wraps to 0 at top of array.
REQ-029 AddrValid in WR or RD SHALL be ignored; the active transfer continues unaltered.
REQ-030 Back-to-back: write may start at cycle A+N+1; read accepted in RD_TAIL overlaps last rdValid with new address phase.
REQ-031 memWE and memRE never both high; busy=0 only in IDLE.

Reset
REQ-032 resetN low: immediately FSM=IDLE, beat counter=0, latched fields=0, all outputs 0.
REQ-033 Reset mid-transfer aborts it: no further memWE/memRE/rdValid; first accepted request is the first AddrValid after resetN rises.

Configuration
REQ-034 MEMCTL_WRAP_EN defined: when wrap=1 and burst=1, beat address k = (offset & ~(BURST_LEN-1)) | ((offset + k) & (BURST_LEN-1)).
REQ-035 MEMCTL_WRAP_EN undefined: wrap input ignored, all bursts linear per REQ-028.

Structure
REQ-036 Package mcDefs SHALL hold the FSM state enum, MEMPAGE constants and PAGE_W default.
REQ-037 Beat address generation SHALL be sub-module mem_addr_gen (offset, beat count, wrap -> memAddr).

Verification
REQ-038 Burst write 0x1000, data 0xA0..0xA3 -> memWE cycles A+1..A+4, memAddr 0..3, busy low at A+5.
REQ-039 Burst read 0x1000 after REQ-038 -> rdValid A+2..A+5, AddrData_out 0xA0..0xA3; single read 0x1002 -> 0xA2 at A+2 only.
REQ-040 Address 0x2005 (other page) -> no memWE/memRE, busy stays 0.
REQ-041 Burst read at 0x1FFE -> memAddr 0xFFE,0xFFF,0x000,0x001; with MEMCTL_WRAP_EN and wrap=1 at 0x1006 -> 6,7,4,5.
REQ-042 resetN low at A+2 of burst write -> outputs 0 asynchronously, only beat 0 written, next AddrValid accepted normally.

Source files
------------

// File: rtl/mem_burst_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mcDefs -- shared definitions for the memory burst controller.
//   * mc_state_e : controller FSM states
//   * MEMPAGE*   : page numbers a controller instance can be told to answer
//   * MC_PAGE_W  : default number of upper address bits used for page decode
// -----------------------------------------------------------------------------
package mcDefs;

  localparam int MC_PAGE_W = 4;

  localparam int MEMPAGE0 = 0;
  localparam int MEMPAGE1 = 1;
  localparam int MEMPAGE2 = 2;
  localparam int MEMPAGE3 = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_TAIL = 2'd3
  } mc_state_e;

endpackage : mcDefs

// File: rtl/mem_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_burst_ctrl_if -- multiplexed address/data bus between a bus master and
// the burst controller.
//   AddrValid    : address-phase strobe (master -> slave)
//   rw           : 1 = read, 0 = write, qualified by AddrValid
//   burst        : 1 = burst transfer, 0 = single beat, qualified by AddrValid
//   wrap         : 1 = wrapping burst, qualified by AddrValid
//   AddrData_in  : address in the address phase, write data in data beats
//   AddrData_out : read data (slave -> master), zero unless rdValid
//   rdValid      : read beat valid on AddrData_out
//   busy         : slave is in the middle of a transfer
// -----------------------------------------------------------------------------
interface mem_burst_ctrl_if #(
  parameter int DATA_W = 16
) ();

  logic              AddrValid;
  logic              rw;
  logic              burst;
  logic              wrap;
  logic [DATA_W-1:0] AddrData_in;
  logic [DATA_W-1:0] AddrData_out;
  logic              rdValid;
  logic              busy;

  modport master (
    output AddrValid, rw, burst, wrap, AddrData_in,
    input  AddrData_out, rdValid, busy
  );

  modport slave (
    input  AddrValid, rw, burst, wrap, AddrData_in,
    output AddrData_out, rdValid, busy
  );

endinterface : mem_burst_ctrl_if

// File: rtl/mem_burst_ctrl_addr_gen.sv
// -----------------------------------------------------------------------------
// mem_addr_gen -- beat address generator for the burst controller.
//   offset : array offset latched in the address phase
//   beat   : beat index within the current transfer
//   wrap   : wrapping burst requested (already qualified with burst)
//   addr   : array word address for this beat
// Build option: MEMCTL_WRAP_EN enables wrapping bursts; without it the wrap
// input has no effect and every burst walks linearly through the array.
// -----------------------------------------------------------------------------
module mem_addr_gen #(
  parameter int OFF_W     = 12,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 2
) (
  input  logic [OFF_W-1:0] offset,
  input  logic [CNT_W-1:0] beat,
  input  logic             wrap,
  output logic [OFF_W-1:0] addr
);

`ifdef MEMCTL_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // Low offset bits that select a word inside a BURST_LEN-aligned block.
  localparam logic [OFF_W-1:0] BLK_MASK = OFF_W'(BURST_LEN - 1);

  logic [OFF_W-1:0] linear;

  // Natural OFF_W-bit overflow gives the wrap to 0 at the top of the array.
  assign linear = offset + OFF_W'(beat);

  // A wrapping burst keeps the aligned block and only cycles the low bits.
  assign addr = (WRAP_EN && wrap) ? ((offset & ~BLK_MASK) | (linear & BLK_MASK))
                                  : linear;

endmodule : mem_addr_gen

// File: rtl/mem_burst_ctrl.sv
// -----------------------------------------------------------------------------
// mem_burst_ctrl -- single-page memory slave translating a multiplexed
// address/data bus into a synchronous word array interface.
//   clk      : single clock, rising edge
//   resetN   : asynchronous active-low reset
//   bus      : mem_burst_ctrl_if.slave (address phase, write data, read data)
//   memAddr  : array word address, zero outside data beats
//   memWE    : array write enable, one cycle per write beat
//   memRE    : array read enable, one cycle per read beat
//   memWdata : array write data, zero outside write beats
//   memRdata : array read data, valid one cycle after memRE
// Build option: MEMCTL_WRAP_EN (see mem_addr_gen) enables wrapping bursts.
// -----------------------------------------------------------------------------
module mem_burst_ctrl
  import mcDefs::*;
#(
  parameter int  DATA_W    = 16,
  parameter int  ADDR_W    = 16,
  parameter int  PAGE_W    = MC_PAGE_W,
  parameter int  PAGE      = MEMPAGE1,
  parameter int  BURST_LEN = 4,
  localparam int OFF_W     = ADDR_W - PAGE_W
) (
  input  logic                clk,
  input  logic                resetN,
  mem_burst_ctrl_if.slave     bus,
  output logic [OFF_W-1:0]    memAddr,
  output logic                memWE,
  output logic                memRE,
  output logic [DATA_W-1:0]   memWdata,
  input  logic [DATA_W-1:0]   memRdata
);

  localparam int CNT_W = $clog2(BURST_LEN);

  mc_state_e        state_q, state_d;
  logic [OFF_W-1:0] off_q;
  logic             burst_q;
  logic             wrap_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rd_valid_q;

  logic             page_hit;
  logic             accept;
  logic             beat_act;
  logic             last_beat;
  logic [OFF_W-1:0] beat_addr;

  mem_addr_gen #(
    .OFF_W     (OFF_W),
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_addr_gen (
    .offset (off_q),
    .beat   (cnt_q),
    .wrap   (wrap_q & burst_q),
    .addr   (beat_addr)
  );

  assign page_hit  = (bus.AddrData_in[ADDR_W-1 -: PAGE_W] == PAGE_W'(PAGE));
  assign last_beat = (cnt_q == (burst_q ? CNT_W'(BURST_LEN - 1) : CNT_W'(0)));

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    beat_act = 1'b0;
    memWE    = 1'b0;
    memRE    = 1'b0;
    case (state_q)
      // RD_TAIL only drains the last read beat, so it can take a new request.
      IDLE, RD_TAIL: begin
        accept  = bus.AddrValid && page_hit;
        state_d = accept ? (bus.rw ? RD : WR) : IDLE;
      end
      WR: begin
        memWE    = 1'b1;
        beat_act = 1'b1;
        if (last_beat) state_d = IDLE;
      end
      RD: begin
        memRE    = 1'b1;
        beat_act = 1'b1;
        if (last_beat) state_d = RD_TAIL;
      end
      default: state_d = IDLE;
    endcase
  end

  // Array-side outputs stay at zero outside their beats.
  assign memAddr  = beat_act ? beat_addr : '0;
  assign memWdata = memWE ? bus.AddrData_in : '0;

  assign bus.busy         = (state_q != IDLE);
  assign bus.rdValid      = rd_valid_q;
  assign bus.AddrData_out = rd_valid_q ? memRdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      off_q      <= '0;
      burst_q    <= 1'b0;
      wrap_q     <= 1'b0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Array read data arrives one cycle after the enable.
      rd_valid_q <= memRE;
      if (accept) begin
        off_q   <= bus.AddrData_in[OFF_W-1:0];
        burst_q <= bus.burst;
        wrap_q  <= bus.wrap;
        cnt_q   <= '0;
      end else if (beat_act) begin
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule : mem_burst_ctrl

// File: tb/tb_mem_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_ctrl -- self-checking bench for mem_burst_ctrl.
// Each accepted request is expanded by a transaction-level model into the
// per-cycle values expected on the array and bus outputs; a simple array
// model answers the controller's memWE/memRE.
// -----------------------------------------------------------------------------
module tb_mem_burst_ctrl;
  import mcDefs::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int PAGE_W = 4;
  localparam int PAGE   = MEMPAGE1;
  localparam int BL     = 4;
  localparam int OFF_W  = ADDR_W - PAGE_W;
  localparam int DEPTH  = 1 << OFF_W;
  localparam int MAXC   = 4096;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  mem_burst_ctrl_if #(.DATA_W(DATA_W)) bus ();

  logic [OFF_W-1:0]  memAddr;
  logic              memWE;
  logic              memRE;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;

  mem_burst_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .PAGE_W    (PAGE_W),
    .PAGE      (PAGE),
    .BURST_LEN (BL)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .bus      (bus),
    .memAddr  (memAddr),
    .memWE    (memWE),
    .memRE    (memRE),
    .memWdata (memWdata),
    .memRdata (memRdata)
  );

  // Synchronous word array attached to the controller.
  bit [DATA_W-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (memWE) env_mem[memAddr] <= memWdata;
    if (memRE) memRdata <= env_mem[memAddr];
  end

  // Reference contents and per-cycle expectations.
  bit [DATA_W-1:0] ref_mem   [DEPTH];
  bit              exp_we    [MAXC];
  bit              exp_re    [MAXC];
  bit              exp_rv    [MAXC];
  bit              exp_busy  [MAXC];
  bit [OFF_W-1:0]  exp_addr  [MAXC];
  bit [OFF_W-1:0]  exp_raddr [MAXC];
  bit [DATA_W-1:0] exp_wdata [MAXC];

  int cyc       = 0;
  int free_from = 0;
  int wbase     = -1;
  int n_checks  = 0;
  int n_pass    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, want);
  endtask

  function automatic int model_addr(input int off, input int k, input bit wrap_eff);
    if (wrap_eff) return (off / BL) * BL + (off + k) % BL;
    return (off + k) % DEPTH;
  endfunction

  task automatic check_outputs();
    check("memWE",        memWE,    exp_we[cyc]);
    check("memRE",        memRE,    exp_re[cyc]);
    check("memAddr",      memAddr,  (exp_we[cyc] || exp_re[cyc]) ? exp_addr[cyc] : '0);
    check("memWdata",     memWdata, exp_we[cyc] ? exp_wdata[cyc] : '0);
    check("rdValid",      bus.rdValid, exp_rv[cyc]);
    check("AddrData_out", bus.AddrData_out, exp_rv[cyc] ? ref_mem[exp_raddr[cyc]] : '0);
    check("busy",         bus.busy, exp_busy[cyc]);
  endtask

  // Expand an accepted request at cycle cyc into its future beats.
  task automatic schedule(input bit rw, input bit burst, input bit wrap, input int off);
    int n;
    bit wrap_eff;
    int a;
    n = burst ? BL : 1;
`ifdef MEMCTL_WRAP_EN
    wrap_eff = wrap && burst;
`else
    wrap_eff = 1'b0;
`endif
    for (int k = 0; k < n; k++) begin
      int t;
      t = cyc + 1 + k;
      a = model_addr(off, k, wrap_eff);
      exp_busy[t] = 1'b1;
      exp_addr[t] = OFF_W'(a);
      if (rw) begin
        exp_re[t]      = 1'b1;
        exp_rv[t+1]    = 1'b1;
        exp_raddr[t+1] = OFF_W'(a);
      end else begin
        exp_we[t]    = 1'b1;
        exp_wdata[t] = (wbase >= 0) ? DATA_W'(wbase + k) : DATA_W'($urandom);
      end
    end
    if (rw) exp_busy[cyc+n+1] = 1'b1;
    free_from = cyc + n + 1;
  endtask

  // One bus cycle: drive inputs, check outputs mid-cycle, advance.
  task automatic step(input bit want, input bit rw, input bit burst, input bit wrap,
                      input logic [DATA_W-1:0] addr);
    bus.AddrValid = want;
    bus.rw        = rw;
    bus.burst     = burst;
    bus.wrap      = wrap;
    if (exp_we[cyc]) begin
      bus.AddrData_in = exp_wdata[cyc];
    end else begin
      bus.AddrData_in = addr;
      if (want && int'(addr[ADDR_W-1 -: PAGE_W]) == PAGE && cyc >= free_from)
        schedule(rw, burst, wrap, int'(addr[OFF_W-1:0]));
    end
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (exp_we[cyc]) ref_mem[exp_addr[cyc]] = exp_wdata[cyc];
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, DATA_W'($urandom));
  endtask

  task automatic req(input bit rw, input bit burst, input bit wrap, input logic [DATA_W-1:0] addr);
    while (cyc < free_from) idle(1);
    step(1'b1, rw, burst, wrap, addr);
  endtask

  // Assert reset in the middle of the current cycle; the transfer is dropped.
  task automatic reset_now();
    bus.AddrValid = 1'b0;
    resetN        = 1'b0;
    for (int i = cyc; i < MAXC; i++) begin
      exp_we[i]   = 1'b0;
      exp_re[i]   = 1'b0;
      exp_rv[i]   = 1'b0;
      exp_busy[i] = 1'b0;
    end
    free_from = cyc;
    #1;
    check_outputs();
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    resetN          = 1'b0;
    bus.AddrValid   = 1'b0;
    bus.rw          = 1'b0;
    bus.burst       = 1'b0;
    bus.wrap        = 1'b0;
    bus.AddrData_in = '0;
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;

    // Burst write then burst read of the same block, single read, back-to-back.
    wbase = 'hA0;
    req(1'b0, 1'b1, 1'b0, 16'h1000);
    wbase = -1;
    req(1'b1, 1'b1, 1'b0, 16'h1000);
    req(1'b1, 1'b0, 1'b0, 16'h1002);
    idle(2);

    // Other page: ignored.
    req(1'b0, 1'b1, 1'b0, 16'h2005);
    req(1'b1, 1'b0, 1'b0, 16'h2005);
    idle(2);

    // Top-of-array roll-over and wrapping burst.
    req(1'b0, 1'b1, 1'b0, 16'h1FFE);
    req(1'b1, 1'b1, 1'b0, 16'h1FFE);
    req(1'b0, 1'b1, 1'b0, 16'h1004);
    req(1'b1, 1'b1, 1'b1, 16'h1006);
    req(1'b0, 1'b1, 1'b1, 16'h1006);
    req(1'b1, 1'b1, 1'b0, 16'h1004);

    // Write right after write.
    req(1'b0, 1'b1, 1'b0, 16'h1100);
    req(1'b0, 1'b0, 1'b0, 16'h1104);
    req(1'b1, 1'b1, 1'b0, 16'h1100);
    idle(3);

    // Reset in the third cycle of a burst write: only beat 0 lands.
    wbase = 'hB0;
    req(1'b0, 1'b1, 1'b0, 16'h1000);
    wbase = -1;
    idle(1);
    reset_now();
    req(1'b1, 1'b1, 1'b0, 16'h1000);
    idle(2);

    // Random traffic, including requests during active transfers.
    for (int i = 0; i < 1200; i++) begin
      bit          want, hit, rw, burst, wrap;
      logic [3:0]  page;
      logic [11:0] off;
      want  = 1'($urandom_range(0, 1));
      hit   = ($urandom_range(0, 4) != 0);
      rw    = 1'($urandom_range(0, 1));
      burst = 1'($urandom_range(0, 1));
      wrap  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       off = 12'hFFC + 12'($urandom_range(0, 3));
        1:       off = 12'($urandom_range(0, 7));
        default: off = 12'($urandom_range(0, 63)) + 12'h100;
      endcase
      page = hit ? 4'(PAGE) : 4'(($urandom_range(0, 14) + 2) % 16);
      if (i == 600) reset_now();
      step(want, rw, burst, wrap, {page, off});
    end
    idle(BL + 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_burst_ctrl
